// File: rtl/alarm_timer.sv
// Deadline-based alarm against a free-running time base: one-shot or
// drift-free periodic expiry, with sticky pending/overrun flags.
module alarm_timer #(
   parameter int COUNTER_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [COUNTER_WIDTH-1:0] now_i,
   input  logic                     arm_i,
   input  logic [COUNTER_WIDTH-1:0] delay_i,
   input  logic                     periodic_i,
   input  logic                     cancel_i,
   input  logic                     ack_i,
   output logic                     fire_o,
   output logic                     pending_o,
   output logic                     overrun_o,
   output logic                     active_o,
   output logic [COUNTER_WIDTH-1:0] remaining_o
);

   typedef enum logic {
      IDLE  = 1'b0,
      ARMED = 1'b1
   } state_t;

   // Largest delay whose deadline is still unambiguous under signed compare.
   localparam logic [COUNTER_WIDTH-1:0] MAX_DELAY = {1'b0, {(COUNTER_WIDTH-1){1'b1}}};

   state_t                   r_state;
   logic [COUNTER_WIDTH-1:0] r_deadline;
   logic [COUNTER_WIDTH-1:0] r_period;
   logic                     r_mode;
   logic                     r_fire;
   logic                     r_pending;
   logic                     r_overrun;
   logic [COUNTER_WIDTH-1:0] r_remaining;

   state_t                   w_state_next;
   logic [COUNTER_WIDTH-1:0] w_deadline_next;
   logic [COUNTER_WIDTH-1:0] w_period_next;
   logic                     w_mode_next;
   logic                     w_fire_next;
   logic                     w_pending_next;
   logic                     w_overrun_next;
   logic [COUNTER_WIDTH-1:0] w_remaining_next;

   logic [COUNTER_WIDTH-1:0] w_delay_clamped;
   logic [COUNTER_WIDTH-1:0] w_diff;
   logic                     w_past_deadline;
   logic                     w_armed;

   assign w_delay_clamped = delay_i[COUNTER_WIDTH-1] ? MAX_DELAY : delay_i;
   // Signed difference keeps the compare correct across counter wrap.
   assign w_diff          = now_i - r_deadline;
   assign w_past_deadline = ($signed(w_diff) >= 0);
   assign w_armed         = (r_state == ARMED);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_deadline  <= '0;
         r_period    <= '0;
         r_mode      <= 1'b0;
         r_fire      <= 1'b0;
         r_pending   <= 1'b0;
         r_overrun   <= 1'b0;
         r_remaining <= '0;
      end else begin
         r_state     <= w_state_next;
         r_deadline  <= w_deadline_next;
         r_period    <= w_period_next;
         r_mode      <= w_mode_next;
         r_fire      <= w_fire_next;
         r_pending   <= w_pending_next;
         r_overrun   <= w_overrun_next;
         r_remaining <= w_remaining_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_deadline_next = r_deadline;
      w_period_next   = r_period;
      w_mode_next     = r_mode;
      w_fire_next     = 1'b0;

      if (arm_i) begin
         w_state_next    = ARMED;
         w_deadline_next = now_i + w_delay_clamped;
         w_period_next   = w_delay_clamped;
         w_mode_next     = periodic_i;
      end else if (cancel_i) begin
         w_state_next = IDLE;
      end else if (w_armed && w_past_deadline) begin
         w_fire_next = 1'b1;
         // Advance from the old deadline, not now_i, so periods never drift.
         if (r_mode && (r_period != '0)) begin
            w_deadline_next = r_deadline + r_period;
         end else begin
            w_state_next = IDLE;
         end
      end
   end

   always_comb begin
      w_pending_next = r_pending;
      w_overrun_next = r_overrun;

      if (w_fire_next) begin
         w_pending_next = 1'b1;
         // An ack racing a new expiry consumes the old one only.
         if (ack_i) begin
            w_overrun_next = 1'b0;
         end else if (r_pending) begin
            w_overrun_next = 1'b1;
         end
      end else if (ack_i) begin
         w_pending_next = 1'b0;
         w_overrun_next = 1'b0;
      end
   end

   always_comb begin
      w_remaining_next = '0;
      if (w_armed && !w_past_deadline) begin
         w_remaining_next = r_deadline - now_i;
      end
   end

   assign fire_o      = r_fire;
   assign pending_o   = r_pending;
   assign overrun_o   = r_overrun;
   assign active_o    = w_armed;
   assign remaining_o = r_remaining;

endmodule

// File: tb/tb_alarm_timer.sv
// Directed bench for alarm_timer: expected fire events are queued by the
// stimulus and consumed by a monitor whenever fire_o is seen.
module tb_alarm_timer;

   logic        clk;
   logic        reset;
   logic [31:0] now_i;
   logic        arm_i;
   logic [31:0] delay_i;
   logic        periodic_i;
   logic        cancel_i;
   logic        ack_i;
   logic        fire_o;
   logic        pending_o;
   logic        overrun_o;
   logic        active_o;
   logic [31:0] remaining_o;

   typedef struct {
      logic [31:0] now;
      logic        pend;
      logic        ovr;
      logic        act;
   } exp_t;

   exp_t sb[$];
   int   n_total = 0;
   int   n_bad   = 0;

   alarm_timer #(.COUNTER_WIDTH(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .now_i       (now_i),
      .arm_i       (arm_i),
      .delay_i     (delay_i),
      .periodic_i  (periodic_i),
      .cancel_i    (cancel_i),
      .ack_i       (ack_i),
      .fire_o      (fire_o),
      .pending_o   (pending_o),
      .overrun_o   (overrun_o),
      .active_o    (active_o),
      .remaining_o (remaining_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%08h", name, act);
      end
   endtask

   task automatic step(input logic [31:0] now, input logic arm, input logic [31:0] dly,
                       input logic per, input logic cancel, input logic ack);
      now_i      = now;
      arm_i      = arm;
      delay_i    = dly;
      periodic_i = per;
      cancel_i   = cancel;
      ack_i      = ack;
      @(posedge clk);
      #1;
   endtask

   task automatic tick(input logic [31:0] now);
      step(now, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic expect_fire(input logic [31:0] now, input logic pend, input logic ovr,
                              input logic act);
      exp_t e;
      e.now  = now;
      e.pend = pend;
      e.ovr  = ovr;
      e.act  = act;
      sb.push_back(e);
   endtask

   // Monitor: fire_o in cycle N+1 belongs to the now_i seen in cycle N.
   initial begin : monitor
      logic [31:0] prev_now;
      exp_t        e;
      prev_now = '0;
      forever begin
         @(negedge clk);
         if (fire_o === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_fire_now", prev_now, 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               chk("fire_now", prev_now, e.now);
               chk("fire_pending", {31'd0, pending_o}, {31'd0, e.pend});
               chk("fire_overrun", {31'd0, overrun_o}, {31'd0, e.ovr});
               chk("fire_active", {31'd0, active_o}, {31'd0, e.act});
            end
         end
         prev_now = now_i;
      end
   end

   initial begin : stimulus
      reset = 1'b1;
      tick(32'd0);
      tick(32'd0);
      chk("rst_fire", {31'd0, fire_o}, 32'd0);
      chk("rst_pending", {31'd0, pending_o}, 32'd0);
      chk("rst_overrun", {31'd0, overrun_o}, 32'd0);
      chk("rst_active", {31'd0, active_o}, 32'd0);
      chk("rst_remaining", remaining_o, 32'd0);
      reset = 1'b0;

      // One-shot: arm at 100 with delay 5
      step(32'd100, 1'b1, 32'd5, 1'b0, 1'b0, 1'b0);
      tick(32'd101);
      tick(32'd102);
      tick(32'd103);
      chk("os_remaining", remaining_o, 32'd2);
      chk("os_active", {31'd0, active_o}, 32'd1);
      tick(32'd104);
      expect_fire(32'd105, 1'b1, 1'b0, 1'b0);
      tick(32'd105);
      chk("os_remaining_exp", remaining_o, 32'd0);
      tick(32'd106);
      chk("os_fire_single", {31'd0, fire_o}, 32'd0);
      step(32'd107, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
      chk("os_ack_pending", {31'd0, pending_o}, 32'd0);

      // Wrap-around deadline
      step(32'hFFFF_FFFE, 1'b1, 32'd4, 1'b0, 1'b0, 1'b0);
      tick(32'hFFFF_FFFF);
      tick(32'd0);
      chk("wrap_remaining", remaining_o, 32'd2);
      tick(32'd1);
      expect_fire(32'd2, 1'b1, 1'b0, 1'b0);
      tick(32'd2);
      step(32'd3, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);

      // Periodic 10: fires at 10, 20, 30; overrun from the second
      step(32'd0, 1'b1, 32'd10, 1'b1, 1'b0, 1'b0);
      for (int t = 1; t <= 30; t++) begin
         if (t % 10 == 0) expect_fire(t, 1'b1, (t != 10), 1'b1);
         tick(t);
      end
      step(32'd31, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
      chk("per_cancel_active", {31'd0, active_o}, 32'd0);
      chk("per_cancel_pending", {31'd0, pending_o}, 32'd1);
      chk("per_cancel_overrun", {31'd0, overrun_o}, 32'd1);
      step(32'd32, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
      chk("per_ack_pending", {31'd0, pending_o}, 32'd0);
      chk("per_ack_overrun", {31'd0, overrun_o}, 32'd0);

      // Cancel in the expiry cycle suppresses the fire
      step(32'd40, 1'b1, 32'd3, 1'b0, 1'b0, 1'b0);
      tick(32'd41);
      tick(32'd42);
      step(32'd43, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
      chk("cancel_exp_active", {31'd0, active_o}, 32'd0);
      tick(32'd44);

      // Arm together with cancel: arm wins
      step(32'd50, 1'b1, 32'd5, 1'b0, 1'b1, 1'b0);
      chk("armcancel_active", {31'd0, active_o}, 32'd1);
      for (int t = 51; t <= 54; t++) tick(t);
      expect_fire(32'd55, 1'b1, 1'b0, 1'b0);
      tick(32'd55);
      step(32'd56, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
      chk("armcancel_ack", {31'd0, pending_o}, 32'd0);

      // Re-arm in the expiry cycle: no fire, new deadline 65
      step(32'd60, 1'b1, 32'd2, 1'b0, 1'b0, 1'b0);
      tick(32'd61);
      step(32'd62, 1'b1, 32'd3, 1'b0, 1'b0, 1'b0);
      tick(32'd63);
      tick(32'd64);
      expect_fire(32'd65, 1'b1, 1'b0, 1'b0);
      tick(32'd65);

      // Ack racing an expiry while pending: pending stays, no overrun
      step(32'd66, 1'b1, 32'd2, 1'b0, 1'b0, 1'b0);
      tick(32'd67);
      expect_fire(32'd68, 1'b1, 1'b0, 1'b0);
      step(32'd68, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
      chk("ackrace_pending", {31'd0, pending_o}, 32'd1);
      chk("ackrace_overrun", {31'd0, overrun_o}, 32'd0);
      step(32'd69, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
      chk("ackrace_clear", {31'd0, pending_o}, 32'd0);

      // Periodic catch-up: period 2, time jumps to 7
      step(32'd0, 1'b1, 32'd2, 1'b1, 1'b0, 1'b0);
      expect_fire(32'd7, 1'b1, 1'b0, 1'b1);
      tick(32'd7);
      expect_fire(32'd7, 1'b1, 1'b1, 1'b1);
      tick(32'd7);
      expect_fire(32'd7, 1'b1, 1'b1, 1'b1);
      tick(32'd7);
      tick(32'd7);
      chk("catchup_remaining", remaining_o, 32'd1);
      step(32'd8, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
      step(32'd9, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);

      // Zero delay fires on the first compare cycle
      step(32'd100, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
      expect_fire(32'd100, 1'b1, 1'b0, 1'b0);
      tick(32'd100);
      tick(32'd101);

      // Oversized delay is clamped to 0x7FFFFFFF
      step(32'd0, 1'b1, 32'h8000_0005, 1'b0, 1'b0, 1'b0);
      tick(32'd1);
      chk("clamp_remaining", remaining_o, 32'h7FFF_FFFE);
      step(32'd2, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

      // Reset one cycle before the fire would appear
      step(32'd200, 1'b1, 32'd3, 1'b0, 1'b0, 1'b0);
      tick(32'd201);
      tick(32'd202);
      reset = 1'b1;
      tick(32'd203);
      reset = 1'b0;
      chk("rstarm_fire", {31'd0, fire_o}, 32'd0);
      chk("rstarm_pending", {31'd0, pending_o}, 32'd0);
      chk("rstarm_overrun", {31'd0, overrun_o}, 32'd0);
      chk("rstarm_active", {31'd0, active_o}, 32'd0);
      chk("rstarm_remaining", remaining_o, 32'd0);
      tick(32'd204);
      tick(32'd205);
      tick(32'd206);

      chk("sb_empty", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
